// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALUop
// codes, datapath mux selects, FSM state encoding and the control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Dense binary encoding; FETCH must stay at 0 (reset / debug view).
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // States that hold a memory request open and therefore run the wait counter.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational map from FSM state (and mem_ready, for the fetch-complete
// write enables) to the datapath control word.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  // Per-state control word; everything not named in a state stays 0.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BEQ_EX: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: instruction sequencing,
// memory wait counting with timeout trap, and illegal-opcode trap.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8    // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic [1:0] ALUop,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state_dbg
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;   // one idle FETCH cycle after a timeout
  logic             illegal_d;
  logic             timeout;
  ctrl_t            ctrl_raw, ctrl;

  // The branch decision is taken in the datapath (PCWriteCond & zero); the
  // flag is part of the control interface but not needed for sequencing.
  logic unused_zero;
  assign unused_zero = zero;

  ctrl_output_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_raw)
  );

  // mem_ready in the timeout cycle completes the access instead of trapping.
  assign timeout = is_mem_state(state_q) && !drop_q && !mem_ready &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Next-state, wait counter and trap decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    drop_d    = 1'b0;
    illegal_d = 1'b0;
    if (drop_q) begin
      state_d = S_FETCH;
    end else if (timeout) begin
      state_d = S_FETCH;
      drop_d  = 1'b1;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) state_d = S_DECODE;
          else           cnt_d   = cnt_q + CNT_W'(1);
        end
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_RTYPE_EX;
            OP_BEQ:       state_d = S_BEQ_EX;
            OP_ADDI:      state_d = S_ADDI_EX;
            OP_J:         state_d = S_JUMP;
            default: begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          if (opcode == OP_LW)      state_d = S_MEMRD;
          else if (opcode == OP_SW) state_d = S_MEMWR;
          else                      state_d = S_FETCH;
        end
        S_MEMRD: begin
          if (mem_ready) state_d = S_MEMWB;
          else           cnt_d   = cnt_q + CNT_W'(1);
        end
        S_MEMWR: begin
          if (mem_ready) state_d = S_FETCH;
          else           cnt_d   = cnt_q + CNT_W'(1);
        end
        S_RTYPE_EX: state_d = S_RTYPE_WB;
        S_ADDI_EX:  state_d = S_ADDI_WB;
        S_MEMWB, S_RTYPE_WB, S_BEQ_EX, S_ADDI_WB, S_JUMP: state_d = S_FETCH;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  // State, counter and post-timeout flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Outputs are forced low during reset and in the idle cycle after a timeout.
  assign ctrl        = (rst_n && !drop_q) ? ctrl_raw : '0;
  assign mem_req     = ctrl.mem_req;
  assign mem_we      = ctrl.mem_we;
  assign IorD        = ctrl.iord;
  assign IRWrite     = ctrl.ir_write;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSource    = ctrl.pc_source;
  assign ALUop       = ctrl.alu_op;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign illegal_op  = rst_n && illegal_d;
  assign bus_error   = rst_n && timeout;
  assign state_dbg   = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: randomized instruction stream with random
// memory latencies; expected per-cycle control words come from an
// instruction-level model and are checked by an independent monitor.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int   TMO = 255;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond;
  logic [1:0] PCSource, ALUop, ALUSrcB;
  logic       ALUSrcA, RegDst, MemtoReg, RegWrite, illegal_op, bus_error;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal_op(illegal_op),
    .bus_error(bus_error), .state_dbg(state_dbg)
  );

  int          checks = 0;
  int          failures = 0;
  int          zsel = -1;
  logic [18:0] expq[$];
  string       tagq[$];

  wire [18:0] got = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond,
                     PCSource, ALUop, ALUSrcA, ALUSrcB, RegDst, MemtoReg,
                     RegWrite, illegal_op, bus_error, (state_dbg == 4'd0)};

  // Control word layout: ..., illegal_op, bus_error, "state is FETCH".
  function automatic logic [18:0] cw(input logic req, we, iord, irw, pcw, pcwc,
                                     input logic [1:0] pcs, aop,
                                     input logic srca,
                                     input logic [1:0] srcb,
                                     input logic rdst, m2r, rw, ill, berr, fet);
    return {req, we, iord, irw, pcw, pcwc, pcs, aop, srca, srcb, rdst, m2r, rw, ill, berr, fet};
  endfunction

  function automatic logic rbit();
    return 1'($urandom & 1);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_ADDI || op == OP_J;
  endfunction

  function automatic logic [18:0] w_fetch(input logic rdy);
    return cw(H,L,L,rdy,rdy,L,2'b00,2'b00,L,2'b01,L,L,L,L,L,H);
  endfunction

  function automatic logic [18:0] w_idle();
    return cw(L,L,L,L,L,L,2'b00,2'b00,L,2'b00,L,L,L,L,L,H);
  endfunction

  // Monitor: every cycle the bench has a prediction for is compared mid-cycle.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      logic [18:0] e;
      string       t;
      e = expq.pop_front();
      t = tagq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got %b required %b (state_dbg=%0d)", t, got, e, state_dbg);
      end
    end
  end

  // One clock of stimulus plus its predicted output word.
  task automatic step(input logic rn, input logic rdy, input logic [5:0] op,
                      input logic [18:0] e, input string t);
    @(posedge clk);
    #1;
    rst_n     = rn;
    mem_ready = rdy;
    opcode    = op;
    zero      = (zsel < 0) ? rbit() : zsel[0];
    expq.push_back(e);
    tagq.push_back(t);
  endtask

  // which: 0 = instruction fetch, 1 = data read, 2 = data write.
  task automatic mem_access(input int which, input int waits, input logic [5:0] op,
                            output logic timed_out);
    logic [18:0] base;
    logic [18:0] fin;
    string       nm;
    logic [5:0]  o;
    timed_out = L;
    if (which == 0) begin
      base = w_fetch(L); fin = w_fetch(H); nm = "fetch";
    end else if (which == 1) begin
      base = cw(H,L,H,L,L,L,2'b00,2'b00,L,2'b00,L,L,L,L,L,L); fin = base; nm = "memrd";
    end else begin
      base = cw(H,H,H,L,L,L,2'b00,2'b00,L,2'b00,L,L,L,L,L,L); fin = base; nm = "memwr";
    end
    for (int i = 0; i < waits; i++) begin
      o = (which == 0) ? 6'($urandom) : op;
      if (i == TMO) begin
        step(H, L, o, base | 19'b10, {nm, "_timeout"});
        step(H, rbit(), 6'($urandom), w_idle(), "after_timeout");
        timed_out = H;
        return;
      end
      step(H, L, o, base, {nm, "_wait"});
    end
    o = (which == 0) ? 6'($urandom) : op;
    step(H, H, o, fin, {nm, "_done"});
  endtask

  // Full instruction: fetch, decode, then the opcode's execution sequence.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    logic to;
    mem_access(0, wf, op, to);
    if (to) return;
    step(H, rbit(), op, cw(L,L,L,L,L,L,2'b00,2'b00,L,2'b11,L,L,L,!is_legal(op),L,L), "decode");
    case (op)
      OP_LW: begin
        step(H, rbit(), op, cw(L,L,L,L,L,L,2'b00,2'b00,H,2'b10,L,L,L,L,L,L), "memadr");
        mem_access(1, wm, op, to);
        if (!to) step(H, rbit(), op, cw(L,L,L,L,L,L,2'b00,2'b00,L,2'b00,L,H,H,L,L,L), "memwb");
      end
      OP_SW: begin
        step(H, rbit(), op, cw(L,L,L,L,L,L,2'b00,2'b00,H,2'b10,L,L,L,L,L,L), "memadr");
        mem_access(2, wm, op, to);
      end
      OP_RTYPE: begin
        step(H, rbit(), op, cw(L,L,L,L,L,L,2'b00,2'b10,H,2'b00,L,L,L,L,L,L), "rtype_ex");
        step(H, rbit(), op, cw(L,L,L,L,L,L,2'b00,2'b00,L,2'b00,H,L,H,L,L,L), "rtype_wb");
      end
      OP_BEQ:
        step(H, rbit(), op, cw(L,L,L,L,L,H,2'b01,2'b01,H,2'b00,L,L,L,L,L,L), "beq_ex");
      OP_ADDI: begin
        step(H, rbit(), op, cw(L,L,L,L,L,L,2'b00,2'b00,H,2'b10,L,L,L,L,L,L), "addi_ex");
        step(H, rbit(), op, cw(L,L,L,L,L,L,2'b00,2'b00,L,2'b00,L,L,H,L,L,L), "addi_wb");
      end
      OP_J:
        step(H, rbit(), op, cw(L,L,L,L,H,L,2'b10,2'b00,L,2'b00,L,L,L,L,L,L), "jump");
      default: ;
    endcase
  endtask

  logic [5:0] rop;
  logic       to_unused;

  initial begin
    step(L, L, 6'd0, w_idle(), "reset");
    step(L, H, 6'd0, w_idle(), "reset");
    run_instr(OP_RTYPE, 0, 0);
    run_instr(OP_LW, 3, 3);
    zsel = 1; run_instr(OP_BEQ, 0, 0);
    zsel = 0; run_instr(OP_BEQ, 0, 0);
    zsel = -1;
    run_instr(6'b111111, 0, 0);
    run_instr(OP_SW, 0, 300);     // write never acknowledged
    run_instr(OP_LW, 1, 255);     // ready arrives exactly at the timeout cycle
    run_instr(OP_J, 260, 0);      // fetch never acknowledged
    run_instr(OP_ADDI, 0, 0);
    // Reset in the middle of a store.
    mem_access(0, 0, OP_SW, to_unused);
    step(H, rbit(), OP_SW, cw(L,L,L,L,L,L,2'b00,2'b00,L,2'b11,L,L,L,L,L,L), "decode");
    step(H, rbit(), OP_SW, cw(L,L,L,L,L,L,2'b00,2'b00,H,2'b10,L,L,L,L,L,L), "memadr");
    step(H, L, OP_SW, cw(H,H,H,L,L,L,2'b00,2'b00,L,2'b00,L,L,L,L,L,L), "memwr_wait");
    step(L, H, OP_SW, w_idle(), "reset_in_memwr");
    step(L, rbit(), OP_SW, w_idle(), "reset_in_memwr");
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0: rop = OP_RTYPE;
        1: rop = OP_LW;
        2: rop = OP_SW;
        3: rop = OP_BEQ;
        4: rop = OP_ADDI;
        5: rop = OP_J;
        default: begin
          rop = 6'($urandom);
          while (is_legal(rop)) rop = 6'($urandom);
        end
      endcase
      run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
